// File: rtl/audio_mux_pkg.sv
// Shared definitions for the audio sample mux: FSM state codes, register
// offsets relative to CTRL_BASE, and bit positions inside the STATUS word.
package audio_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Offsets from CTRL_BASE
    localparam int OFF_CTRL    = 0;
    localparam int OFF_BUFSIZE = 1;
    localparam int OFF_STATUS  = 2;

    // CTRL write bits
    localparam int CTRL_ACT_BIT = 0;
    localparam int CTRL_CLR_BIT = 1;

    // STATUS layout (counter occupies the low FIFO_WIDTH+1 bits)
    localparam int STAT_STATE_LSB = 16;
    localparam int STAT_SHORT_BIT = 18;
    localparam int STAT_CFG_BIT   = 19;

endpackage

// File: rtl/syncro_2.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports: clk - destination clock; din - async input; dout - synchronized output.
// Deliberately unreset: the output is valid two clocks after din settles.
module syncro_2 (
    input  logic clk,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk) begin
        meta <= din;
        dout <= meta;
    end

endmodule

// File: rtl/audio_mux_mc.sv
// Audio sample mux with host register interface and block-capture sequencer.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   address/read/write  - host register bus; datain write data,
//   datain, dataout       dataout registered read data
//   sound_in            - NUM_CH packed samples, channel c at [c*D +: D]
//   xxxx_top            - voice-cycle top pulse
//   lrck, run           - asynchronous word clock and run level
//   ch_read             - per-channel read pulse (combinational)
//   trig                - sample trigger (lrck in I2S mode, block trigger otherwise)
//   i2s_enable          - high when BUFSIZE==0
//   sample_ready        - sample/block available
//
// state | meaning
// IDLE  | no block in progress; counter held at 0
// FILL  | counting run_trig pulses toward BUFSIZE
// DONE  | block complete; waiting for act to drop
module audio_mux_mc
    import audio_mux_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int AUD_BIT_DEPTH = 24,
    parameter int FIFO_WIDTH    = 6,
    parameter int ADDR_W        = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ADDR_W-1:0]               address,
    input  logic                            read,
    input  logic                            write,
    input  logic [31:0]                     datain,
    output logic [31:0]                     dataout,
    input  logic [NUM_CH*AUD_BIT_DEPTH-1:0] sound_in,
    input  logic                            xxxx_top,
    input  logic                            lrck,
    input  logic                            run,
    output logic [NUM_CH-1:0]               ch_read,
    output logic                            trig,
    output logic                            i2s_enable,
    output logic                            sample_ready
);

    localparam int D         = AUD_BIT_DEPTH;
    localparam int CW        = FIFO_WIDTH + 1;
    localparam int CTRL_BASE = 2 ** (ADDR_W - 1);

    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(CTRL_BASE + OFF_CTRL);
    localparam logic [ADDR_W-1:0] A_BUFSIZE = ADDR_W'(CTRL_BASE + OFF_BUFSIZE);
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(CTRL_BASE + OFF_STATUS);

    logic          lrck_sync, run_sync;
    logic          act, act_dly;
    logic [CW-1:0] bufsize, counter, cnt_next;
    state_t        state;
    logic          short_err, cfg_err;
    logic          run_trig, trig_blk;

    logic          wr_ctrl, wr_buf, clr_flags;
    logic          act_rise, act_fall, i2s_mode, final_trig;
    logic          set_short, set_cfg;
    logic          ch_hit;
    logic [31:0]   ch_word, status_word, rd_data;
    logic          unused_datain;

    syncro_2 u_sync_lrck (.clk(clk), .din(lrck), .dout(lrck_sync));
    syncro_2 u_sync_run  (.clk(clk), .din(run),  .dout(run_sync));

    assign unused_datain = ^datain;

    assign wr_ctrl    = write && (address == A_CTRL);
    assign wr_buf     = write && (address == A_BUFSIZE);
    assign clr_flags  = wr_ctrl && datain[CTRL_CLR_BIT];
    assign act_rise   = act && !act_dly;
    assign act_fall   = !act && act_dly;
    assign i2s_mode   = (bufsize == '0);
    assign cnt_next   = counter + CW'(1);
    assign final_trig = run_trig && (cnt_next == bufsize);
    // A drop of act on the same cycle as the last trigger still counts as a full block.
    assign set_short  = (state == ST_FILL) && act_fall && !final_trig;
    assign set_cfg    = wr_buf && (state != ST_IDLE);

    always_comb begin
        ch_read = '0;
        ch_word = '0;
        ch_hit  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (address == ADDR_W'(c)) begin
                ch_read[c] = read;
                ch_hit     = 1'b1;
                // Sample is left-justified; low bits read back as zero.
                ch_word    = 32'(sound_in[c*D +: D]) << (32 - D);
            end
        end
    end

    always_comb begin
        status_word                           = '0;
        status_word[CW-1:0]                   = counter;
        status_word[STAT_STATE_LSB +: 2]      = state;
        status_word[STAT_SHORT_BIT]           = short_err;
        status_word[STAT_CFG_BIT]             = cfg_err;
    end

    always_comb begin
        rd_data = '0;
        if (ch_hit)                    rd_data = ch_word;
        else if (address == A_CTRL)    rd_data = {31'b0, act};
        else if (address == A_BUFSIZE) rd_data = 32'(bufsize);
        else if (address == A_STATUS)  rd_data = status_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act       <= 1'b0;
            act_dly   <= 1'b0;
            bufsize   <= '0;
            counter   <= '0;
            state     <= ST_IDLE;
            short_err <= 1'b0;
            cfg_err   <= 1'b0;
            dataout   <= '0;
            run_trig  <= 1'b0;
            trig_blk  <= 1'b0;
        end else begin
            act_dly <= act;
            if (wr_ctrl)
                act <= datain[CTRL_ACT_BIT];
            // BUFSIZE is frozen while a block is in flight.
            if (wr_buf && state == ST_IDLE)
                bufsize <= datain[CW-1:0];
            if (read)
                dataout <= rd_data;

            run_trig <= xxxx_top && (state == ST_FILL) && !run_sync;
            trig_blk <= run_trig && (state == ST_FILL);

            // Set wins over a simultaneous clear.
            short_err <= set_short || (short_err && !clr_flags);
            cfg_err   <= set_cfg   || (cfg_err   && !clr_flags);

            case (state)
                ST_IDLE: begin
                    counter <= '0;
                    if (act_rise && !i2s_mode)
                        state <= ST_FILL;
                end
                ST_FILL: begin
                    if (act_fall) begin
                        state   <= ST_IDLE;
                        counter <= '0;
                    end else if (run_trig) begin
                        counter <= cnt_next;
                        if (cnt_next == bufsize)
                            state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (act_fall) begin
                        state   <= ST_IDLE;
                        counter <= '0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    counter <= '0;
                end
            endcase
        end
    end

    assign i2s_enable   = i2s_mode;
    assign trig         = i2s_mode ? lrck_sync : trig_blk;
    assign sample_ready = i2s_mode || (state == ST_DONE);

endmodule

// File: tb/tb_audio_mux_mc.sv
module tb_audio_mux_mc;
    import audio_mux_pkg::*;

    localparam int NCH = 4;
    localparam int D   = 24;
    localparam int FW  = 6;
    localparam int AW  = 4;
    localparam logic [AW-1:0] A_CTRL    = AW'(8 + OFF_CTRL);
    localparam logic [AW-1:0] A_BUFSIZE = AW'(8 + OFF_BUFSIZE);
    localparam logic [AW-1:0] A_STATUS  = AW'(8 + OFF_STATUS);

    logic           clk = 1'b0;
    logic           reset;
    logic [AW-1:0]  address;
    logic           read, write;
    logic [31:0]    datain, dataout;
    logic [NCH*D-1:0] sound_in;
    logic           xxxx_top, lrck, run;
    logic [NCH-1:0] ch_read;
    logic           trig, i2s_enable, sample_ready;

    audio_mux_mc #(.NUM_CH(NCH), .AUD_BIT_DEPTH(D), .FIFO_WIDTH(FW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .datain(datain), .dataout(dataout), .sound_in(sound_in), .xxxx_top(xxxx_top),
        .lrck(lrck), .run(run), .ch_read(ch_read), .trig(trig),
        .i2s_enable(i2s_enable), .sample_ready(sample_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int trig_cnt = 0;
    bit m_short, m_cfg;
    logic [31:0] rdv;
    logic [23:0] ch_val [NCH];

    always @(negedge clk) if (trig && !i2s_enable) trig_cnt++;

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        address = a; datain = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        tick();
        read = 1'b0;
        d = dataout;
    endtask

    task automatic top_pulse();
        xxxx_top = 1'b1; tick(); xxxx_top = 1'b0; tick(4);
    endtask

    function automatic logic [31:0] st_word(int cnt, int st, bit sh, bit cf);
        return (32'(cf) << 19) | (32'(sh) << 18) | (32'(st) << 16) | 32'(cnt);
    endfunction

    // Reference: a block of b samples fed n top pulses produces min(n,b) triggers,
    // completes iff n >= b, and an early drop of act flags a short block.
    task automatic run_block(input int b, input int n);
        int base, exp_cnt;
        bit done;
        exp_cnt = (n < b) ? n : b;
        done    = (n >= b);
        wr(A_BUFSIZE, 32'(b));
        wr(A_CTRL, 32'd1);
        tick();
        rd(A_STATUS, rdv);
        check("blk_fill_status", rdv, st_word(0, 1, m_short, m_cfg));
        check("blk_fill_ready", 32'(sample_ready), 32'd0);
        check("blk_i2s_en", 32'(i2s_enable), 32'd0);
        base = trig_cnt;
        for (int i = 0; i < n; i++) top_pulse();
        tick(3);
        check("blk_trig_count", 32'(trig_cnt - base), 32'(exp_cnt));
        rd(A_STATUS, rdv);
        check("blk_end_status", rdv, st_word(exp_cnt, done ? 2 : 1, m_short, m_cfg));
        check("blk_end_ready", 32'(sample_ready), 32'(done));
        wr(A_CTRL, 32'd0);
        tick();
        if (!done) m_short = 1'b1;
        rd(A_STATUS, rdv);
        check("blk_drop_status", rdv, st_word(0, 0, m_short, m_cfg));
        wr(A_CTRL, 32'd2);
        m_short = 1'b0;
        rd(A_STATUS, rdv);
        check("blk_clear_status", rdv, st_word(0, 0, m_short, m_cfg));
    endtask

    initial begin
        int base;
        logic old;
        reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; datain = '0;
        sound_in = '0; xxxx_top = 1'b0; lrck = 1'b0; run = 1'b0;
        m_short = 1'b0; m_cfg = 1'b0;
        tick(4);
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_dataout", dataout, 32'd0);
        check("rst_i2s_en", 32'(i2s_enable), 32'd1);
        check("rst_ready", 32'(sample_ready), 32'd1);
        rd(A_CTRL, rdv);    check("rst_ctrl", rdv, 32'd0);
        rd(A_BUFSIZE, rdv); check("rst_bufsize", rdv, 32'd0);
        rd(A_STATUS, rdv);  check("rst_status", rdv, 32'd0);

        // I2S pass-through: trig tracks lrck two clocks later
        for (int i = 0; i < 6; i++) begin
            old  = lrck;
            lrck = ~lrck;
            tick();
            check("i2s_trig_1clk", 32'(trig), 32'(old));
            tick();
            check("i2s_trig_2clk", 32'(trig), 32'(lrck));
            tick($urandom_range(0, 3));
        end

        // Channel reads
        for (int c = 0; c < NCH; c++) ch_val[c] = 24'($urandom);
        ch_val[2] = 24'hABCDEF;
        for (int c = 0; c < NCH; c++) sound_in[c*D +: D] = ch_val[c];
        for (int c = 0; c < NCH; c++) begin
            address = AW'(c); read = 1'b1;
            #1;
            check("ch_read_onehot", 32'(ch_read), 32'(1) << c);
            tick();
            read = 1'b0;
            check("ch_dataout", dataout, {ch_val[c], 8'h00});
        end
        address = AW'(5); read = 1'b1; #1;
        check("unmapped_ch_read", 32'(ch_read), 32'd0);
        tick(); read = 1'b0;
        check("unmapped_dataout", dataout, 32'd0);
        rd(AW'(2), rdv);  check("ch2_abcdef", rdv, 32'hABCDEF00);
        rd(AW'(14), rdv); check("unmapped_hi", rdv, 32'd0);

        // Directed full block: 6 pulses into a 4-sample block
        run_block(4, 6);

        // Short block with simultaneous sticky set and clear: set wins
        wr(A_BUFSIZE, 32'd4);
        wr(A_CTRL, 32'd1);
        tick();
        base = trig_cnt;
        top_pulse(); top_pulse();
        tick(3);
        check("short_trigs", 32'(trig_cnt - base), 32'd2);
        wr(A_CTRL, 32'd0);
        wr(A_CTRL, 32'd2);
        rd(A_STATUS, rdv);
        check("short_set_wins", rdv, st_word(0, 0, 1, 0));
        wr(A_CTRL, 32'd2);
        rd(A_STATUS, rdv);
        check("short_cleared", rdv, st_word(0, 0, 0, 0));

        // Random blocks
        for (int k = 0; k < 5; k++)
            run_block($urandom_range(1, 8), $urandom_range(0, 10));

        // BUFSIZE write during FILL is rejected; run=1 suppresses triggers
        wr(A_BUFSIZE, 32'd4);
        wr(A_CTRL, 32'd1);
        tick();
        top_pulse();
        wr(A_BUFSIZE, 32'd8);
        m_cfg = 1'b1;
        rd(A_BUFSIZE, rdv);
        check("cfg_bufsize_kept", rdv, 32'd4);
        rd(A_STATUS, rdv);
        check("cfg_err_status", rdv, st_word(1, 1, 0, 1));
        run = 1'b1;
        tick(3);
        base = trig_cnt;
        top_pulse(); top_pulse();
        tick(2);
        check("run_no_trig", 32'(trig_cnt - base), 32'd0);
        rd(A_STATUS, rdv);
        check("run_counter_hold", rdv, st_word(1, 1, 0, 1));
        run = 1'b0;
        tick(3);
        top_pulse(); top_pulse();
        tick(2);
        rd(A_STATUS, rdv);
        check("fill_count3", rdv, st_word(3, 1, 0, 1));

        // Reset mid-FILL
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_cfg = 1'b0;
        check("midrst_dataout", dataout, 32'd0);
        check("midrst_i2s_en", 32'(i2s_enable), 32'd1);
        rd(A_STATUS, rdv);  check("midrst_status", rdv, 32'd0);
        rd(A_BUFSIZE, rdv); check("midrst_bufsize", rdv, 32'd0);
        rd(A_CTRL, rdv);    check("midrst_ctrl", rdv, 32'd0);
        wr(A_BUFSIZE, 32'd3);
        tick(2);
        rd(A_STATUS, rdv);
        check("midrst_no_restart", rdv, st_word(0, 0, 0, 0));

        // act drop coinciding with the final trigger: complete block, no flag
        wr(A_CTRL, 32'd1);
        tick();
        top_pulse(); top_pulse();
        rd(A_STATUS, rdv);
        check("coin_pre_status", rdv, st_word(2, 1, 0, 0));
        xxxx_top = 1'b1; address = A_CTRL; datain = 32'd0; write = 1'b1;
        tick();
        xxxx_top = 1'b0; write = 1'b0;
        tick(3);
        rd(A_STATUS, rdv);
        check("coin_no_short", rdv, st_word(0, 0, 0, 0));
        check("coin_ready", 32'(sample_ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_mux_mc.md
AUDIO_MUX_MC -- requirements
Module: audio_mux_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of audio channels, 1..2**(ADDR_W-1).
REQ-002 SHALL have parameter AUD_BIT_DEPTH, default 24: sample width, 1..32.
REQ-003 SHALL have parameter FIFO_WIDTH, default 6: buffer-size/counter width is FIFO_WIDTH+1.
REQ-004 SHALL have parameter ADDR_W, default 4: register address width; CTRL_BASE = 2**(ADDR_W-1).
REQ-005 SHALL have ports: clk  in  1  sole clock; reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: address  in  ADDR_W  register address; read  in  1  read strobe; write  in  1  write strobe; datain  in  32  write data; dataout  out  32  registered read data.
REQ-007 SHALL have ports: sound_in  in  NUM_CH*AUD_BIT_DEPTH  channel samples, channel c at bits [c*D +: D]; xxxx_top  in  1  voice-cycle top pulse; lrck  in  1  async I2S word clock; run  in  1  async run level.
REQ-008 SHALL have ports: ch_read  out  NUM_CH  per-channel read pulse; trig  out  1  sample trigger; i2s_enable  out  1  I2S mode flag; sample_ready  out  1  block/sample available.

Function
REQ-009 ch_read[c] SHALL be combinational: read && address==c, for c < NUM_CH.
REQ-010 Read of address c < NUM_CH SHALL load dataout[31:32-D] with channel c and dataout[31-D:0] with 0, one clock latency; reads of unmapped addresses SHALL load 0.
REQ-011 CTRL at CTRL_BASE+0: write bit0 = act (host block active); write bit1 = 1 clears sticky flags (self-clearing); read returns {30'b0, 1'b0, act}.
REQ-012 BUFSIZE at CTRL_BASE+1: write datain[FIFO_WIDTH:0]; read returns it zero-extended; write accepted only in state IDLE, otherwise ignored and cfg_err set.
REQ-013 STATUS at CTRL_BASE+2 (read-only): [FIFO_WIDTH:0] counter, [17:16] state code, [18] short_err, [19] cfg_err, others 0.
REQ-014 lrck and run SHALL each pass through a 2-flop synchronizer before use.
REQ-015 I2S mode (BUFSIZE==0): i2s_enable=1, trig = synchronized lrck, sample_ready=1, FSM held in IDLE, counter 0.
REQ-016 Block mode (BUFSIZE!=0): i2s_enable=0; trig = registered run_trig; run_trig = xxxx_top && state==FILL && !run_synced, asserted one cycle after the qualifying xxxx_top.
REQ-017 FSM states: IDLE(0), FILL(1), DONE(2).
REQ-018 IDLE -> FILL on act rising edge (act_dly=0, act=1) with BUFSIZE!=0; counter cleared to 0.
REQ-019 FILL: counter +1 on each run_trig; counter reaching BUFSIZE -> DONE same cycle as final increment; counter never exceeds BUFSIZE.
REQ-020 FILL -> IDLE on act falling edge before completion; counter cleared; short_err set.
REQ-021 DONE: sample_ready=1, no further triggers; act falling edge -> IDLE, counter cleared.
REQ-022 Act falling edge coinciding with the final run_trig SHALL take FILL -> IDLE, no short_err (block counted complete).
REQ-023 Simultaneous sticky-set and clear SHALL result in flag set.
REQ-024 In block mode sample_ready SHALL be 0 in IDLE and FILL.

Reset
REQ-025 reset SHALL force: act=0, act_dly=0, BUFSIZE=0, counter=0, state IDLE, short_err=0, cfg_err=0, dataout=0, run_trig=0.
REQ-026 Synchronizer flops are not reset; trig in I2S mode valid 2 clocks after reset release.
REQ-027 Reset mid-FILL SHALL abort the block with no flag set; next block requires a new act rising edge.

Structure
REQ-028 State codes, register offsets (CTRL, BUFSIZE, STATUS) and STATUS bit positions SHALL live in shared package audio_mux_pkg.
REQ-029 Synchronizers SHALL instantiate existing sub-module syncro_2 (two instances); no other sub-modules.

Verification
REQ-030 BUFSIZE=0, toggle lrck -> trig follows lrck after 2 clk, i2s_enable=1, sample_ready=1.
REQ-031 BUFSIZE=4, act 0->1, 6 xxxx_top pulses, run=0 -> exactly 4 trig pulses, STATUS counter=4, state DONE, sample_ready=1.
REQ-032 BUFSIZE=4, act falls after 2 trigs -> state IDLE, counter 0, short_err=1; CTRL bit1 write -> short_err=0.
REQ-033 NUM_CH=4, D=24, sound_in ch2=24'hABCDEF, read addr 2 -> ch_read=4'b0100 same cycle, dataout=32'hABCDEF00 next cycle.
REQ-034 In FILL, write BUFSIZE=8 -> BUFSIZE unchanged, cfg_err=1; run=1 during FILL -> no trig, counter holds.
REQ-035 reset asserted mid-FILL (counter=3) -> next cycle counter=0, IDLE, flags 0, BUFSIZE=0.
